// File: rtl/instr_mem_pipe.sv
// Byte-addressed big-endian instruction memory for the fetch stage: latency-configurable
// read pipeline, fetch flush, fault flags, byte-enabled program-load port and post-reset clear.
module instr_mem_pipe #(
  parameter int unsigned ADDR_W         = 14,
  parameter int unsigned LATENCY        = 1,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        flush,
  output logic        rsp_valid,
  output logic [31:0] rsp_instr,
  output logic [31:0] rsp_addr,
  output logic [1:0]  rsp_fault,
  input  logic        ld_en,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data,
  input  logic [3:0]  ld_be,
  output logic        busy
);

  localparam int unsigned WA      = ADDR_W - 2;
  localparam int unsigned DEPTH_W = 2 ** WA;

  typedef enum logic {S_CLEAR, S_RUN} state_t;
  localparam state_t RST_STATE = CLEAR_ON_RESET ? S_CLEAR : S_RUN;

  state_t        state_q, state_d;
  logic [WA-1:0] clr_cnt_q, clr_cnt_d;

  // Lane 3 holds the byte at the lowest address, so a word reads out MSB first.
  logic [3:0][7:0] mem [DEPTH_W];

  logic          accept;
  logic [1:0]    req_fault;
  logic          ld_oor;
  logic          ld_we;
  logic [WA-1:0] rd_idx, ld_idx;
  logic [31:0]   rd_word;
  logic          unused_ld_lsb;

  logic [LATENCY-1:0] vld_q;
  logic [31:0]        instr_q [LATENCY];
  logic [31:0]        addr_q  [LATENCY];
  logic [1:0]         fault_q [LATENCY];

  assign busy      = (state_q == S_CLEAR);
  assign req_ready = rst_n && (state_q == S_RUN) && !ld_en;
  assign accept    = req_valid && req_ready;

  assign req_fault[0] = |req_addr[1:0];
  assign req_fault[1] = (req_addr >> ADDR_W) != '0;
  assign ld_oor       = (ld_addr >> ADDR_W) != '0;
  assign ld_we        = (state_q == S_RUN) && ld_en && !ld_oor;

  assign rd_idx        = req_addr[ADDR_W-1:2];
  assign ld_idx        = ld_addr[ADDR_W-1:2];
  assign rd_word       = mem[rd_idx];
  assign unused_ld_lsb = ^ld_addr[1:0];

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      S_CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == WA'(DEPTH_W - 1)) state_d = S_RUN;
      end
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RST_STATE;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == S_CLEAR) begin
      mem[clr_cnt_q] <= '0;
    end else if (ld_we) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (ld_be[b]) mem[ld_idx][b] <= ld_data[8*b +: 8];
      end
    end
  end

  // Flush kills everything already in flight but not the request accepted at the flush edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int unsigned i = 0; i < LATENCY; i++) begin
        instr_q[i] <= '0;
        addr_q[i]  <= '0;
        fault_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= accept;
      if (accept) begin
        instr_q[0] <= (req_fault != '0) ? '0 : rd_word;
        addr_q[0]  <= req_addr;
        fault_q[0] <= req_fault;
      end
      for (int unsigned i = 1; i < LATENCY; i++) begin
        vld_q[i]   <= vld_q[i-1] && !flush;
        instr_q[i] <= instr_q[i-1];
        addr_q[i]  <= addr_q[i-1];
        fault_q[i] <= fault_q[i-1];
      end
    end
  end

  // A response already on the output when flush arrives belongs to the old path.
  assign rsp_valid = vld_q[LATENCY-1] && !flush;
  assign rsp_instr = instr_q[LATENCY-1];
  assign rsp_addr  = addr_q[LATENCY-1];
  assign rsp_fault = fault_q[LATENCY-1];

endmodule

// File: tb/tb_instr_mem_pipe.sv
// Randomised and directed checks of instr_mem_pipe against a byte-array reference model.
module tb_instr_mem_pipe;

  localparam int unsigned AW    = 8;
  localparam int unsigned LAT   = 3;
  localparam int unsigned DEPTH = 2 ** (AW - 2);
  localparam int unsigned BYTES = 2 ** AW;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        flush = 1'b0;
  logic        rsp_valid;
  logic [31:0] rsp_instr;
  logic [31:0] rsp_addr;
  logic [1:0]  rsp_fault;
  logic        ld_en = 1'b0;
  logic [31:0] ld_addr = '0;
  logic [31:0] ld_data = '0;
  logic [3:0]  ld_be = '0;
  logic        busy;

  instr_mem_pipe #(.ADDR_W(AW), .LATENCY(LAT), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .flush(flush), .rsp_valid(rsp_valid), .rsp_instr(rsp_instr),
    .rsp_addr(rsp_addr), .rsp_fault(rsp_fault), .ld_en(ld_en), .ld_addr(ld_addr),
    .ld_data(ld_data), .ld_be(ld_be), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned due;
    logic [31:0] instr;
    logic [31:0] addr;
    logic [1:0]  fault;
  } rsp_t;

  rsp_t        exp_q[$];
  logic [7:0]  mem_m [BYTES];
  bit          run_m;
  int unsigned clr_m;
  int unsigned edge_n;
  int          n_chk = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic rsp_t predict(input logic [31:0] a, input int unsigned due);
    rsp_t r;
    int   i;
    r.due      = due;
    r.addr     = a;
    r.fault[0] = (a[1:0] != 2'b00);
    r.fault[1] = (a >= BYTES);
    r.instr    = '0;
    if (r.fault == 2'b00) begin
      i = int'(a);
      r.instr = {mem_m[i], mem_m[i+1], mem_m[i+2], mem_m[i+3]};
    end
    return r;
  endfunction

  task automatic model_load(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    int base;
    base = int'(a) & ~3;
    for (int b = 0; b < 4; b++)
      if (be[3-b]) mem_m[base+b] = d[31-8*b -: 8];
  endtask

  // Inputs are set by the caller just after a falling edge.
  task automatic cycle();
    rsp_t h;
    bit   acc;
    #1;
    chk("req_ready", {31'b0, req_ready}, {31'b0, run_m && !ld_en});
    chk("busy", {31'b0, busy}, {31'b0, !run_m});
    if (exp_q.size() > 0 && exp_q[0].due == edge_n) begin
      h = exp_q.pop_front();
      chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, !flush});
      if (!flush) begin
        chk("rsp_instr", rsp_instr, h.instr);
        chk("rsp_addr", rsp_addr, h.addr);
        chk("rsp_fault", {30'b0, rsp_fault}, {30'b0, h.fault});
      end
    end else begin
      chk("rsp_valid_idle", {31'b0, rsp_valid}, 32'd0);
    end
    @(posedge clk);
    edge_n++;
    acc = req_valid && run_m && !ld_en;
    if (flush) exp_q.delete();
    if (acc) exp_q.push_back(predict(req_addr, edge_n + LAT - 1));
    if (run_m && ld_en && ld_addr < BYTES) model_load(ld_addr, ld_data, ld_be);
    if (!run_m) begin
      clr_m++;
      if (clr_m == DEPTH) run_m = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    req_valid = 1'b0; ld_en = 1'b0; flush = 1'b0;
  endtask

  task automatic idle_cycles(input int unsigned n);
    idle();
    repeat (n) cycle();
  endtask

  task automatic fetch(input logic [31:0] a);
    idle(); req_valid = 1'b1; req_addr = a;
    cycle();
    idle();
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    idle(); ld_en = 1'b1; ld_addr = a; ld_data = d; ld_be = be;
    cycle();
    idle();
  endtask

  task automatic do_reset(input int unsigned hold);
    idle();
    rst_n = 1'b0;
    exp_q.delete();
    run_m = 1'b0;
    clr_m = 0;
    foreach (mem_m[i]) mem_m[i] = '0;
    #1;
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd1);
    chk("rst_rsp_instr", rsp_instr, 32'd0);
    chk("rst_rsp_addr", rsp_addr, 32'd0);
    chk("rst_rsp_fault", {30'b0, rsp_fault}, 32'd0);
    repeat (hold) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    if ($urandom_range(0, 9) < 7) a = 32'($urandom_range(0, BYTES - 1)) & 32'hFFFF_FFFC;
    else                          a = 32'($urandom_range(0, 2 * BYTES - 1));
    return a;
  endfunction

  initial begin
    edge_n = 0;
    do_reset(2);

    // Clear window with random traffic: nothing may be accepted or written.
    repeat (DEPTH + 4) begin
      req_valid = 1'($urandom_range(0, 1));
      req_addr  = rand_addr();
      ld_en     = 1'($urandom_range(0, 1));
      ld_addr   = rand_addr();
      ld_data   = $urandom();
      ld_be     = 4'($urandom());
      cycle();
    end

    for (int unsigned i = 0; i < DEPTH; i++) load(32'(i * 4), $urandom(), 4'hF);
    for (int unsigned i = 0; i < 8; i++) fetch(32'(i * 8));
    idle_cycles(LAT + 1);

    do_reset(1);
    idle_cycles(20);
    do_reset(1);
    idle_cycles(DEPTH);

    for (int unsigned a = 0; a < BYTES; a += 4) begin
      req_valid = 1'b1; req_addr = 32'(a);
      cycle();
    end
    idle_cycles(LAT + 1);

    load(32'h64, 32'h4808_0000, 4'hF);
    fetch(32'h64);
    load(32'h10, 32'h1122_3344, 4'hF);
    load(32'h10, 32'hAABB_CCDD, 4'b0101);
    fetch(32'h10);
    load(32'h10, 32'h0, 4'hF);
    idle_cycles(LAT + 1);

    fetch(32'h66);
    fetch(32'h100);
    fetch(32'h102);
    idle_cycles(LAT + 1);

    req_valid = 1'b1;
    req_addr = 32'h00; cycle();
    req_addr = 32'h04; cycle();
    req_addr = 32'h08; cycle();
    req_addr = 32'h40; flush = 1'b1; cycle();
    idle_cycles(LAT + 1);

    req_valid = 1'b1; req_addr = 32'h20;
    ld_en = 1'b1; ld_addr = 32'h24; ld_data = 32'hDEAD_BEEF; ld_be = 4'hF;
    cycle();
    ld_en = 1'b0;
    cycle();
    idle_cycles(LAT + 1);

    req_valid = 1'b1;
    req_addr = 32'h24; cycle();
    req_addr = 32'h28; cycle();
    do_reset(1);
    idle_cycles(DEPTH + LAT);

    repeat (600) begin
      req_valid = ($urandom_range(0, 9) < 7);
      req_addr  = rand_addr();
      ld_en     = ($urandom_range(0, 9) < 2);
      ld_addr   = rand_addr();
      ld_data   = $urandom();
      ld_be     = 4'($urandom());
      flush     = ($urandom_range(0, 9) == 0);
      cycle();
    end
    idle_cycles(LAT + 2);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
